// File: rtl/lsu_stage.sv
// lsu_stage: load/store stage with a single-outstanding valid/ready data-memory port.
// Upstream: agu_* micro-op fields, agu_valid/lsu_ready handshake, flush.
// Memory:   dmem_req_valid/ready, dmem_addr/we/be/wdata request; dmem_rsp_valid/rdata response.
// Results:  one-cycle pulses wb_valid (load data), st_done (store), exc_valid (misaligned),
//           with wb_rd_addr/wb_data/wb_pc/exc_addr.
module lsu_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            agu_valid,
    output logic            lsu_ready,
    input  logic [XLEN-1:0] agu_pc,
    input  logic            agu_is_store,
    input  logic            agu_is_signed,
    input  logic [XLEN-1:0] agu_store_data,
    input  logic [XLEN-1:0] agu_access_addr,
    input  logic [3:0]      agu_byte_sel,
    input  logic [RD_W-1:0] agu_rd_addr,
    input  logic            agu_align_exc,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] wb_pc,
    output logic            st_done,
    output logic            exc_valid,
    output logic [XLEN-1:0] exc_addr
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, addr_q, addr_d, wdata_q, wdata_d;
    logic            we_q, we_d, signed_q, signed_d, discard_q, discard_d;
    logic [3:0]      be_q, be_d, sel_q, sel_d;
    logic [1:0]      off_q, off_d;
    logic [RD_W-1:0] rd_q, rd_d, wb_rd_addr_q, wb_rd_addr_d;
    logic            wb_valid_q, wb_valid_d, st_done_q, st_done_d, exc_valid_q, exc_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d, wb_pc_q, wb_pc_d, exc_addr_q, exc_addr_d;
    logic            accept;
    logic [XLEN-1:0] shifted, load_data;

    assign lsu_ready = (state_q == IDLE) && !flush;
    assign accept    = agu_valid && lsu_ready;

    // Size is taken from the unshifted byte mask latched at accept.
    assign shifted   = dmem_rdata >> {off_q, 3'b000};
    assign load_data = (sel_q == 4'b0001) ? {{(XLEN-8){signed_q & shifted[7]}}, shifted[7:0]} :
                       (sel_q == 4'b0011) ? {{(XLEN-16){signed_q & shifted[15]}}, shifted[15:0]} :
                       shifted;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        signed_d     = signed_q;
        discard_d    = discard_q;
        be_d         = be_q;
        sel_d        = sel_q;
        off_d        = off_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        st_done_d    = 1'b0;
        exc_valid_d  = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_data_d    = wb_data_q;
        wb_pc_d      = wb_pc_q;
        exc_addr_d   = exc_addr_q;
        case (state_q)
            IDLE: begin
                if (accept && agu_align_exc) begin
                    exc_valid_d = 1'b1;
                    exc_addr_d  = agu_access_addr;
                    wb_pc_d     = agu_pc;
                end else if (accept) begin
                    state_d   = REQ;
                    pc_d      = agu_pc;
                    addr_d    = {agu_access_addr[XLEN-1:2], 2'b00};
                    off_d     = agu_access_addr[1:0];
                    be_d      = agu_byte_sel << agu_access_addr[1:0];
                    wdata_d   = agu_store_data << {agu_access_addr[1:0], 3'b000};
                    we_d      = agu_is_store;
                    signed_d  = agu_is_signed;
                    sel_d     = agu_byte_sel;
                    rd_d      = agu_rd_addr;
                    discard_d = 1'b0;
                end
            end
            REQ: begin
                // A flush cannot cancel a request the memory has already taken.
                if (dmem_req_ready && we_q) begin
                    state_d = IDLE;
                    if (!flush) begin
                        st_done_d = 1'b1;
                        wb_pc_d   = pc_q;
                    end
                end else if (dmem_req_ready) begin
                    state_d   = WAIT;
                    discard_d = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    state_d = IDLE;
                    if (!(discard_q || flush)) begin
                        wb_valid_d   = 1'b1;
                        wb_data_d    = load_data;
                        wb_rd_addr_d = rd_q;
                        wb_pc_d      = pc_q;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            discard_q    <= 1'b0;
            be_q         <= '0;
            sel_q        <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            st_done_q    <= 1'b0;
            exc_valid_q  <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
            wb_pc_q      <= '0;
            exc_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            discard_q    <= discard_d;
            be_q         <= be_d;
            sel_q        <= sel_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            st_done_q    <= st_done_d;
            exc_valid_q  <= exc_valid_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
            wb_pc_q      <= wb_pc_d;
            exc_addr_q   <= exc_addr_d;
        end
    end

    assign dmem_req_valid = (state_q == REQ);
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_be        = be_q;
    assign dmem_wdata     = wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd_addr     = wb_rd_addr_q;
    assign wb_data        = wb_data_q;
    assign wb_pc          = wb_pc_q;
    assign st_done        = st_done_q;
    assign exc_valid      = exc_valid_q;
    assign exc_addr       = exc_addr_q;
endmodule

// File: tb/tb_lsu_stage.sv
// tb_lsu_stage: randomized transaction bench for lsu_stage against an arithmetic reference model.
module tb_lsu_stage;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0, rst_n = 1'b0, flush = 1'b0, agu_valid = 1'b0;
    logic            lsu_ready;
    logic [XLEN-1:0] agu_pc = '0, agu_store_data = '0, agu_access_addr = '0;
    logic            agu_is_store = 1'b0, agu_is_signed = 1'b0, agu_align_exc = 1'b0;
    logic [3:0]      agu_byte_sel = 4'b0001;
    logic [RD_W-1:0] agu_rd_addr = '0;
    logic            dmem_req_valid, dmem_req_ready = 1'b0, dmem_we;
    logic [XLEN-1:0] dmem_addr, dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_rsp_valid = 1'b0;
    logic [XLEN-1:0] dmem_rdata = '0;
    logic            wb_valid, st_done, exc_valid;
    logic [RD_W-1:0] wb_rd_addr;
    logic [XLEN-1:0] wb_data, wb_pc, exc_addr;

    int n_tests = 0;
    int n_fail  = 0;

    lsu_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .agu_valid(agu_valid), .lsu_ready(lsu_ready),
        .agu_pc(agu_pc), .agu_is_store(agu_is_store), .agu_is_signed(agu_is_signed),
        .agu_store_data(agu_store_data), .agu_access_addr(agu_access_addr),
        .agu_byte_sel(agu_byte_sel), .agu_rd_addr(agu_rd_addr), .agu_align_exc(agu_align_exc),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .wb_pc(wb_pc),
        .st_done(st_done), .exc_valid(exc_valid), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] m_be(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input int off);
        longint v;
        v = (longint'(d) * (longint'(1) << (8 * off))) % (longint'(1) << 32);
        return v[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] r, input int off, input int n, input bit sgn);
        longint w;
        w = (longint'(r) / (longint'(1) << (8 * off))) % (longint'(1) << (8 * n));
        if (sgn && w >= (longint'(1) << (8 * n - 1)))
            w = w - (longint'(1) << (8 * n));
        return w[31:0];
    endfunction

    // fmode: 0 none, 1 flush while request stalled, 2 flush in WAIT, 3 flush on the handshake
    task automatic run_op(input bit st, input int n, input bit sgn, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rdata, input logic [31:0] pc,
                          input logic [4:0] rd, input int rdly, input int rspdly, input int fmode);
        bit misal, discard, done;
        int off;
        off   = int'(addr % 4);
        misal = (off % n) != 0;
        agu_valid = 1'b1; agu_is_store = st; agu_is_signed = sgn; agu_access_addr = addr;
        agu_store_data = data; agu_pc = pc; agu_rd_addr = rd; agu_align_exc = misal;
        agu_byte_sel = 4'((1 << n) - 1);
        flush = 1'b0;
        #1 check("accept_ready", lsu_ready, 1);
        @(negedge clk);
        agu_valid = 1'b0;
        #1;
        if (misal) begin
            check("exc_pulses", {wb_valid, st_done, exc_valid}, 3'b001);
            check("exc_addr", exc_addr, addr);
            check("exc_pc", wb_pc, pc);
            check("exc_no_req", dmem_req_valid, 0);
            check("exc_ready", lsu_ready, 1);
            return;
        end
        done = 0;
        for (int c = 0; !done; c++) begin
            dmem_req_ready = (c >= rdly);
            flush = (fmode == 1 && c == 0 && rdly > 0) || (fmode == 3 && c >= rdly);
            #1;
            check("req_valid", dmem_req_valid, 1);
            check("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            check("req_be", dmem_be, m_be(n, off));
            check("req_we", dmem_we, st);
            if (st) check("req_wdata", dmem_wdata, m_wdata(data, off));
            check("req_busy", lsu_ready, 0);
            check("req_pulses", {wb_valid, st_done, exc_valid}, 3'b000);
            done = dmem_req_ready || flush;
            @(negedge clk);
            dmem_req_ready = 1'b0;
            flush = 1'b0;
        end
        #1;
        if (fmode == 1 && rdly > 0) begin
            check("drop_no_req", dmem_req_valid, 0);
            check("drop_ready", lsu_ready, 1);
            check("drop_pulses", {wb_valid, st_done, exc_valid}, 3'b000);
            return;
        end
        if (st) begin
            check("st_pulses", {wb_valid, st_done, exc_valid}, fmode == 3 ? 3'b000 : 3'b010);
            if (fmode != 3) check("st_pc", wb_pc, pc);
            check("st_ready", lsu_ready, 1);
            return;
        end
        discard = (fmode == 3);
        done = 0;
        for (int c = 0; !done; c++) begin
            dmem_rsp_valid = (c >= rspdly);
            dmem_rdata = dmem_rsp_valid ? rdata : $urandom();
            flush = (fmode == 2 && c == 0);
            if (flush) discard = 1;
            #1;
            check("wait_no_req", dmem_req_valid, 0);
            check("wait_busy", lsu_ready, 0);
            check("wait_pulses", {wb_valid, st_done, exc_valid}, 3'b000);
            done = dmem_rsp_valid;
            @(negedge clk);
            dmem_rsp_valid = 1'b0;
            flush = 1'b0;
        end
        #1;
        check("ld_pulses", {wb_valid, st_done, exc_valid}, discard ? 3'b000 : 3'b100);
        if (!discard) begin
            check("ld_data", wb_data, m_load(rdata, off, n, sgn));
            check("ld_rd", wb_rd_addr, rd);
            check("ld_pc", wb_pc, pc);
        end
        check("ld_ready", lsu_ready, 1);
    endtask

    // Idle cycle with a possible stray response, which must be ignored.
    task automatic idle_cycle();
        @(negedge clk);
        dmem_rsp_valid = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1;
        check("idle_pulses", {wb_valid, st_done, exc_valid}, 3'b000);
        check("idle_no_req", dmem_req_valid, 0);
    endtask

    initial begin
        int n, sz, fm, rdly;
        bit st;
        logic [31:0] a;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", lsu_ready, 1);
        check("rst_outs", |{dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
                            wb_valid, wb_rd_addr, wb_data, wb_pc, st_done, exc_valid, exc_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 4, 0, 32'h1000, 0, 32'hDEADBEEF, 32'h400, 5, 0, 0, 0);
        run_op(0, 1, 1, 32'h1003, 0, 32'h80FF0000, 32'h404, 6, 0, 0, 0);
        run_op(0, 1, 0, 32'h1003, 0, 32'h80FF0000, 32'h408, 7, 0, 0, 0);
        run_op(0, 2, 1, 32'h1002, 0, 32'h80FF0000, 32'h40C, 8, 0, 0, 0);
        run_op(1, 2, 0, 32'h2002, 32'h1234ABCD, 0, 32'h410, 0, 0, 0, 0);
        run_op(0, 4, 0, 32'h1000, 0, 32'h11223344, 32'h414, 9, 4, 0, 0);
        run_op(0, 4, 0, 32'h1001, 0, 0, 32'h418, 3, 0, 0, 0);
        run_op(0, 4, 0, 32'h1004, 0, 32'h55667788, 32'h41C, 4, 0, 2, 2);
        run_op(0, 4, 0, 32'h1008, 0, 32'h99AABBCC, 32'h420, 10, 0, 0, 0);
        run_op(1, 4, 0, 32'h3000, 32'hCAFEF00D, 0, 32'h424, 0, 2, 0, 1);
        idle_cycle();

        // Accept and flush together: flush wins.
        agu_valid = 1'b1; agu_align_exc = 1'b1; flush = 1'b1;
        #1 check("flush_blocks_ready", lsu_ready, 0);
        @(negedge clk);
        agu_valid = 1'b0; agu_align_exc = 1'b0; flush = 1'b0;
        #1;
        check("flush_no_accept", {dmem_req_valid, exc_valid}, 2'b00);

        // Async reset while waiting for a load response.
        agu_valid = 1'b1; agu_is_store = 1'b0; agu_access_addr = 32'h1000; agu_byte_sel = 4'b1111;
        @(negedge clk);
        agu_valid = 1'b0; dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", |{dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
                             wb_valid, wb_rd_addr, wb_data, wb_pc, st_done, exc_valid, exc_addr}, 0);
        check("arst_ready", lsu_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        #1 check("arst_stale_rsp", {wb_valid, st_done, exc_valid}, 3'b000);

        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 2);
            n = 1 << sz;
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            rdly = $urandom_range(0, 3);
            fm = $urandom_range(0, 7);
            fm = (fm > 3) ? 0 : fm;
            if (fm == 1 && rdly == 0) rdly = 1;
            if (fm == 2 && st) fm = 0;
            run_op(st, n, 1'($urandom_range(0, 1)), a, $urandom(), $urandom(), $urandom(),
                   5'($urandom_range(0, 31)), rdly, $urandom_range(0, 3), fm);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
